// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit adder/subtractor; the carry chain is cut into STAGES chunks,
// each added in its own register stage, with a valid/ready stream on both sides.
module pipe_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf
);

    localparam int CW   = WIDTH / STAGES;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] valid_q, valid_d;
    logic [STAGES-1:0] carry_q, carry_d;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  a_d   [STAGES];
    logic [WIDTH-1:0]  bp_q  [STAGES];
    logic [WIDTH-1:0]  bp_d  [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];
    logic [WIDTH-1:0]  sum_d [STAGES];

    logic [STAGES-1:0] src_valid;
    logic [STAGES-1:0] src_c;
    logic [WIDTH-1:0]  src_a   [STAGES];
    logic [WIDTH-1:0]  src_bp  [STAGES];
    logic [WIDTH-1:0]  src_sum [STAGES];

    logic              en;
    logic [CW:0]       chunk;

    // Stage 0 is fed by the ports (subtract folds into ~b and an inverted carry-in);
    // every later stage is fed by the register of the stage before it.
    for (genvar k = 0; k < STAGES; k++) begin : g_src
        if (k == 0) begin : g_first
            assign src_valid[k] = in_valid;
            assign src_a[k]     = a;
            assign src_bp[k]    = sub ? ~b : b;
            assign src_c[k]     = sub ? ~ci : ci;
            assign src_sum[k]   = '0;
        end else begin : g_next
            assign src_valid[k] = valid_q[k-1];
            assign src_a[k]     = a_q[k-1];
            assign src_bp[k]    = bp_q[k-1];
            assign src_c[k]     = carry_q[k-1];
            assign src_sum[k]   = sum_q[k-1];
        end
    end

    always_comb begin
        en       = !valid_q[LAST] || out_ready;
        in_ready = en;
        valid_d  = valid_q;
        carry_d  = carry_q;
        a_d      = a_q;
        bp_d     = bp_q;
        sum_d    = sum_q;
        chunk    = '0;
        for (int k = 0; k < STAGES; k++) begin
            chunk = {1'b0, src_a[k][k*CW +: CW]} + {1'b0, src_bp[k][k*CW +: CW]}
                  + {{CW{1'b0}}, src_c[k]};
            if (en) begin
                valid_d[k] = src_valid[k];
                // Bubbles move the valid bit only; data registers keep their last operation.
                if (src_valid[k]) begin
                    a_d[k]                = src_a[k];
                    bp_d[k]               = src_bp[k];
                    sum_d[k]              = src_sum[k];
                    sum_d[k][k*CW +: CW]  = chunk[CW-1:0];
                    carry_d[k]            = chunk[CW];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                bp_q[k]  <= '0;
                sum_q[k] <= '0;
            end
        end else begin
            valid_q <= valid_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            bp_q    <= bp_d;
            sum_q   <= sum_d;
        end
    end

    assign out_valid = valid_q[LAST];
    assign s         = sum_q[LAST];
    assign co        = carry_q[LAST];
    assign ovf       = (a_q[LAST][WIDTH-1] == bp_q[LAST][WIDTH-1])
                    && (sum_q[LAST][WIDTH-1] != a_q[LAST][WIDTH-1]);

endmodule

// File: tb/tb_pipe_adder.sv
// Randomised and directed bench for pipe_adder; every accepted operation is
// predicted with plain integer arithmetic and matched in order at the output.
module tb_pipe_adder;

    localparam int W  = 32;
    localparam int ST = 4;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         ci_i;
    logic         sub_i;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         co;
    logic         ovf;

    pipe_adder #(.WIDTH(W), .STAGES(ST)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a_i),
        .b         (b_i),
        .ci        (ci_i),
        .sub       (sub_i),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .co        (co),
        .ovf       (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] s;
        logic         co;
        logic         ovf;
        int           cyc;
        int           stalls;
    } exp_t;

    exp_t          exp_q[$];
    exp_t          e;
    int            n_checks  = 0;
    int            n_errors  = 0;
    int            cyc       = 0;
    int            stall_cnt = 0;
    int            n_out     = 0;
    logic          prev_stall = 1'b0;
    logic [W+2:0]  prev_out  = '0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, expv, cyc);
        end
    endtask

    // Reference: exact integer result, then reduced mod 2^W; overflow is the
    // signed result leaving the representable range.
    function automatic exp_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic civ, input logic subv);
        exp_t   r;
        longint ua, ub, sa, sb, c, u, sr;
        ua = longint'(av);
        ub = longint'(bv);
        sa = longint'($signed(av));
        sb = longint'($signed(bv));
        c  = longint'(civ);
        if (!subv) begin
            u  = ua + ub + c;
            sr = sa + sb + c;
            r.co = (u >= (64'sd1 <<< W));
        end else begin
            u  = ua - ub - c;
            sr = sa - sb - c;
            r.co = (u >= 0);
        end
        r.s      = u[W-1:0];
        r.ovf    = (sr > ((64'sd1 <<< (W-1)) - 1)) || (sr < -(64'sd1 <<< (W-1)));
        r.cyc    = 0;
        r.stalls = 0;
        return r;
    endfunction

    always @(negedge clk) begin
        cyc++;
        if (!rst_n) begin
            exp_q.delete();
            prev_stall = 1'b0;
        end else begin
            chk("in_ready", in_ready, !out_valid || out_ready);
            if (prev_stall)
                chk("stall_hold", {out_valid, co, ovf, s}, prev_out);
            if (out_valid && exp_q.size() == 0) begin
                chk("spurious_out", out_valid, 1'b0);
            end else if (out_valid && out_ready) begin
                e = exp_q.pop_front();
                n_out++;
                chk("s", s, e.s);
                chk("co", co, e.co);
                chk("ovf", ovf, e.ovf);
                if (e.stalls == stall_cnt)
                    chk("latency", cyc - e.cyc, ST);
            end
            prev_stall = out_valid && !out_ready;
            if (prev_stall) stall_cnt++;
            prev_out = {out_valid, co, ovf, s};
            if (in_valid && in_ready) begin
                e        = model(a_i, b_i, ci_i, sub_i);
                e.cyc    = cyc;
                e.stalls = stall_cnt;
                exp_q.push_back(e);
            end
        end
    end

    // Called just after a rising edge; returns just after the edge that accepted.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic civ, input logic subv);
        int n;
        n        = 0;
        in_valid = 1'b1;
        a_i      = av;
        b_i      = bv;
        ci_i     = civ;
        sub_i    = subv;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("send_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_rand();
        send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    logic [11:0] pat;
    int          out_before;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        a_i       = 32'h1234_5678;
        b_i       = 32'h0F0F_0F0F;
        ci_i      = 1'b1;
        sub_i     = 1'b0;
        pat       = 12'b1010_1100_0001;

        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            chk("rst_out_valid", out_valid, 1'b0);
            chk("rst_s", s, '0);
            chk("rst_co", co, 1'b0);
            chk("rst_ovf", ovf, 1'b0);
            chk("rst_in_ready", in_ready, 1'b1);
        end
        @(posedge clk);
        #1;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        repeat (8) begin
            @(negedge clk);
            chk("post_rst_idle", out_valid, 1'b0);
        end
        @(posedge clk);
        #1;

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        repeat (6) @(posedge clk);
        #1;

        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0);
        send(32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        send(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1);
        send(32'h0000_0003, 32'h0000_0004, 1'b1, 1'b0);
        send(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        repeat (6) @(posedge clk);
        #1;

        for (int i = 0; i < 16; i++) send_rand();
        repeat (6) @(posedge clk);
        #1;

        fork
            begin
                for (int i = 0; i < 10; i++) send_rand();
            end
            begin
                for (int c = 0; c < 60; c++) begin
                    @(posedge clk);
                    #1;
                    out_ready = pat[c % 12];
                end
                out_ready = 1'b1;
            end
        join
        repeat (10) @(posedge clk);
        #1;
        chk("drain_stream", exp_q.size(), 0);

        out_before = n_out;
        send_rand();
        send_rand();
        send_rand();
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_pulse_ov", out_valid, 1'b0);
        @(posedge clk);
        #1;
        send(32'hDEAD_BEEF, 32'h2152_4111, 1'b1, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        chk("flush_count", n_out - out_before, 1);
        chk("drain_final", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
